// File: rtl/rename_map_table_if.sv
// Dispatch-side bundle between the decode slots / free list and the rename map table.
// Widths default from the global N_WAY and CDB_BITS macros.
`ifndef N_WAY
`define N_WAY 3
`endif
`ifndef CDB_BITS
`define CDB_BITS 6
`endif

interface rename_map_table_if #(
    parameter int N_WAY    = `N_WAY,
    parameter int CDB_BITS = `CDB_BITS
);
    localparam int CNT_W = $clog2(N_WAY) + 1;

    // Handshake: there is no per-slot ready. accept_num is the ready side for the
    // instruction group (slot i is taken iff i < accept_num), and dispatch_num tells
    // the free list how many tags (entries 0..dispatch_num-1) were consumed.
    logic [N_WAY-1:0]                inst_valid;
    logic [N_WAY-1:0]                dest_valid;
    logic [N_WAY-1:0][4:0]           dest_areg;
    logic [N_WAY-1:0][4:0]           src1_areg;
    logic [N_WAY-1:0][4:0]           src2_areg;
    logic [N_WAY-1:0][CDB_BITS-1:0]  free_list_out;
    logic [CNT_W-1:0]                free_num;
    logic [N_WAY-1:0]                cdb_valid;
    logic [N_WAY-1:0][CDB_BITS-1:0]  cdb_tag;
    logic                            squash;
    logic [31:0][CDB_BITS-1:0]       arch_map;

    logic [CNT_W-1:0]                accept_num;
    logic [CNT_W-1:0]                dispatch_num;
    logic [N_WAY-1:0][CDB_BITS-1:0]  rename_T;
    logic [N_WAY-1:0][CDB_BITS-1:0]  rename_Told;
    logic [N_WAY-1:0][CDB_BITS-1:0]  src1_tag;
    logic [N_WAY-1:0][CDB_BITS-1:0]  src2_tag;
    logic [N_WAY-1:0]                src1_rdy;
    logic [N_WAY-1:0]                src2_rdy;

    modport master (
        output inst_valid, dest_valid, dest_areg, src1_areg, src2_areg,
               free_list_out, free_num, cdb_valid, cdb_tag, squash, arch_map,
        input  accept_num, dispatch_num, rename_T, rename_Told,
               src1_tag, src2_tag, src1_rdy, src2_rdy
    );

    modport slave (
        input  inst_valid, dest_valid, dest_areg, src1_areg, src2_areg,
               free_list_out, free_num, cdb_valid, cdb_tag, squash, arch_map,
        output accept_num, dispatch_num, rename_T, rename_Told,
               src1_tag, src2_tag, src1_rdy, src2_rdy
    );
endinterface

// File: rtl/rename_map_table.sv
// N-way register rename map table: combinational renaming, map/ready update on posedge.
// Optional MAP_CDB_BYPASS_EN: same-cycle CDB hits mark map-derived sources ready.
module rename_map_table #(
    parameter int N_WAY    = `N_WAY,
    parameter int CDB_BITS = `CDB_BITS
) (
    input  logic                  clock,
    input  logic                  reset,
    rename_map_table_if.slave     bus
);
    localparam int CNT_W = $clog2(N_WAY) + 1;
    localparam int TW    = CDB_BITS;

    logic [31:0][TW-1:0]      map_tag;
    logic [31:0]              map_rdy;
    logic [N_WAY-1:0]         eff_dest;
    logic [N_WAY-1:0]         slot_acc;
    logic [CNT_W-1:0]         acc_cnt;
    logic [CNT_W-1:0]         dsp_cnt;
    logic [N_WAY-1:0][TW-1:0] new_tag;

`ifdef MAP_CDB_BYPASS_EN
    function automatic logic cdb_hit(input logic [TW-1:0] tag);
        logic hit;
        hit = 1'b0;
        for (int k = 0; k < N_WAY; k++)
            if (bus.cdb_valid[k] && bus.cdb_tag[k] == tag) hit = 1'b1;
        return hit;
    endfunction
`endif

    // Accept the longest valid prefix whose destination count fits the free tags.
    always_comb begin : accept_logic
        logic             blocked;
        logic [CNT_W-1:0] need;
        acc_cnt  = '0;
        dsp_cnt  = '0;
        blocked  = 1'b0;
        eff_dest = '0;
        need     = '0;
        for (int i = 0; i < N_WAY; i++) begin
            eff_dest[i] = bus.dest_valid[i] && (bus.dest_areg[i] != 5'd0);
            need = dsp_cnt + CNT_W'(eff_dest[i]);
            if (blocked || !bus.inst_valid[i] || need > bus.free_num) begin
                blocked = 1'b1;
            end else begin
                acc_cnt = CNT_W'(i + 1);
                dsp_cnt = need;
            end
        end
    end

    always_comb begin : alloc_logic
        int idx;
        idx      = 0;
        new_tag  = '0;
        slot_acc = '0;
        for (int i = 0; i < N_WAY; i++) begin
            slot_acc[i] = (CNT_W'(i) < acc_cnt);
            if (eff_dest[i]) begin
                new_tag[i] = bus.free_list_out[idx];
                idx = idx + 1;
            end
        end
    end

    // Intra-group forwarding: the latest earlier writer of an areg overrides the map.
    always_comb begin : rename_logic
        bus.rename_T    = new_tag;
        bus.rename_Told = '0;
        bus.src1_tag    = '0;
        bus.src2_tag    = '0;
        bus.src1_rdy    = '0;
        bus.src2_rdy    = '0;
        for (int i = 0; i < N_WAY; i++) begin
            bus.rename_Told[i] = map_tag[bus.dest_areg[i]];
            bus.src1_tag[i]    = map_tag[bus.src1_areg[i]];
            bus.src2_tag[i]    = map_tag[bus.src2_areg[i]];
`ifdef MAP_CDB_BYPASS_EN
            bus.src1_rdy[i] = map_rdy[bus.src1_areg[i]] | cdb_hit(map_tag[bus.src1_areg[i]]);
            bus.src2_rdy[i] = map_rdy[bus.src2_areg[i]] | cdb_hit(map_tag[bus.src2_areg[i]]);
`else
            bus.src1_rdy[i] = map_rdy[bus.src1_areg[i]];
            bus.src2_rdy[i] = map_rdy[bus.src2_areg[i]];
`endif
            for (int j = 0; j < N_WAY; j++) begin
                if (j < i && eff_dest[j]) begin
                    if (bus.dest_areg[j] == bus.dest_areg[i]) bus.rename_Told[i] = new_tag[j];
                    if (bus.dest_areg[j] == bus.src1_areg[i]) begin
                        bus.src1_tag[i] = new_tag[j];
                        bus.src1_rdy[i] = 1'b0;
                    end
                    if (bus.dest_areg[j] == bus.src2_areg[i]) begin
                        bus.src2_tag[i] = new_tag[j];
                        bus.src2_rdy[i] = 1'b0;
                    end
                end
            end
            if (bus.src1_areg[i] == 5'd0) begin
                bus.src1_tag[i] = '0;
                bus.src1_rdy[i] = 1'b1;
            end
            if (bus.src2_areg[i] == 5'd0) begin
                bus.src2_tag[i] = '0;
                bus.src2_rdy[i] = 1'b1;
            end
        end
    end

    assign bus.accept_num   = (reset || bus.squash) ? '0 : acc_cnt;
    assign bus.dispatch_num = (reset || bus.squash) ? '0 : dsp_cnt;

    // CDB wakeups are issued first so a same-cycle dispatch to the areg overrides them.
    always_ff @(posedge clock) begin
        if (reset) begin
            for (int a = 0; a < 32; a++) map_tag[a] <= TW'(a);
            map_rdy <= '1;
        end else if (bus.squash) begin
            map_tag <= bus.arch_map;
            map_rdy <= '1;
        end else begin
            for (int a = 0; a < 32; a++)
                for (int k = 0; k < N_WAY; k++)
                    if (bus.cdb_valid[k] && map_tag[a] == bus.cdb_tag[k]) map_rdy[a] <= 1'b1;
            for (int i = 0; i < N_WAY; i++) begin
                if (slot_acc[i] && eff_dest[i]) begin
                    map_tag[bus.dest_areg[i]] <= new_tag[i];
                    map_rdy[bus.dest_areg[i]] <= 1'b0;
                end
            end
        end
    end
endmodule

// File: tb/tb_rename_map_table.sv
// Randomized scoreboard bench for rename_map_table with a sequential per-slot reference model.
module tb_rename_map_table;
    localparam int NW = `N_WAY;
    localparam int TW = `CDB_BITS;
`ifdef MAP_CDB_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    typedef struct {
        int acc;
        int dsp;
        int t[NW];
        int told[NW];
        int s1[NW];
        int s2[NW];
        int r1[NW];
        int r2[NW];
    } exp_t;

    logic clk;
    logic reset;
    int   n_checks;
    int   n_fail;
    exp_t exp_q[$];
    exp_t mon_e;
    int   m_tag[32];
    bit   m_rdy[32];

    rename_map_table_if #(.N_WAY(NW), .CDB_BITS(TW)) bus ();

    rename_map_table #(.N_WAY(NW), .CDB_BITS(TW)) dut (
        .clock (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic bit cdb_match(input int tag);
        for (int k = 0; k < NW; k++)
            if (bus.cdb_valid[k] && int'(bus.cdb_tag[k]) == tag) return 1'b1;
        return 1'b0;
    endfunction

    // Reference model: rename each accepted slot in program order against a working map.
    task automatic issue();
        exp_t e;
        int   wt[32];
        bit   grp[32];
        int   used, acc, a;
        bit   eff;
        for (int r = 0; r < 32; r++) begin
            wt[r]  = m_tag[r];
            grp[r] = 1'b0;
        end
        acc = 0;
        used = 0;
        for (int i = 0; i < NW; i++) begin
            eff = bus.dest_valid[i] && bus.dest_areg[i] != 0;
            if (!bus.inst_valid[i] || used + int'(eff) > int'(bus.free_num)) break;
            acc = i + 1;
            used = used + int'(eff);
        end
        used = 0;
        for (int i = 0; i < NW; i++) begin
            e.t[i] = 0; e.told[i] = 0; e.s1[i] = 0; e.s2[i] = 0; e.r1[i] = 0; e.r2[i] = 0;
            if (i < acc) begin
                a = int'(bus.src1_areg[i]);
                e.s1[i] = (a == 0) ? 0 : wt[a];
                e.r1[i] = (a == 0) ? 1 : (grp[a] ? 0 : int'(m_rdy[a] | (BYP & cdb_match(wt[a]))));
                a = int'(bus.src2_areg[i]);
                e.s2[i] = (a == 0) ? 0 : wt[a];
                e.r2[i] = (a == 0) ? 1 : (grp[a] ? 0 : int'(m_rdy[a] | (BYP & cdb_match(wt[a]))));
                a = int'(bus.dest_areg[i]);
                if (bus.dest_valid[i] && a != 0) begin
                    e.told[i] = wt[a];
                    e.t[i] = int'(bus.free_list_out[used]);
                    used++;
                    wt[a] = e.t[i];
                    grp[a] = 1'b1;
                end
            end
        end
        e.acc = (reset || bus.squash) ? 0 : acc;
        e.dsp = (reset || bus.squash) ? 0 : used;
        exp_q.push_back(e);
        @(posedge clk);
        if (reset) begin
            for (int r = 0; r < 32; r++) begin m_tag[r] = r; m_rdy[r] = 1'b1; end
        end else if (bus.squash) begin
            for (int r = 0; r < 32; r++) begin m_tag[r] = int'(bus.arch_map[r]); m_rdy[r] = 1'b1; end
        end else begin
            for (int r = 0; r < 32; r++) begin
                if (grp[r]) begin m_tag[r] = wt[r]; m_rdy[r] = 1'b0; end
                else if (cdb_match(m_tag[r])) m_rdy[r] = 1'b1;
            end
        end
        #1;
    endtask

    task automatic idle();
        bus.inst_valid = '0; bus.dest_valid = '0; bus.dest_areg = '0;
        bus.src1_areg = '0; bus.src2_areg = '0; bus.free_list_out = '0;
        bus.free_num = '0; bus.cdb_valid = '0; bus.cdb_tag = '0; bus.squash = 1'b0;
        for (int r = 0; r < 32; r++) bus.arch_map[r] = TW'(r);
    endtask

    task automatic set_slot(input int i, input int d, input int dv, input int s1, input int s2);
        bus.inst_valid[i] = 1'b1;
        bus.dest_valid[i] = dv[0];
        bus.dest_areg[i]  = 5'(d);
        bus.src1_areg[i]  = 5'(s1);
        bus.src2_areg[i]  = 5'(s2);
    endtask

    task automatic set_free(input int f0, input int f1, input int f2, input int n);
        int f[3];
        f = '{f0, f1, f2};
        for (int i = 0; i < NW && i < 3; i++) bus.free_list_out[i] = TW'(f[i]);
        bus.free_num = ($clog2(NW) + 1)'(n);
    endtask

    task automatic random_cycle();
        idle();
        bus.inst_valid = NW'($urandom_range(0, (1 << NW) - 1));
        if ($urandom_range(0, 3) != 0) bus.inst_valid = NW'((1 << $urandom_range(0, NW)) - 1);
        for (int i = 0; i < NW; i++) begin
            bus.dest_valid[i] = 1'($urandom_range(0, 1));
            bus.dest_areg[i]  = 5'($urandom_range(0, 1) ? $urandom_range(0, 7) : $urandom_range(0, 31));
            bus.src1_areg[i]  = 5'($urandom_range(0, 1) ? $urandom_range(0, 7) : $urandom_range(0, 31));
            bus.src2_areg[i]  = 5'($urandom_range(0, 31));
            bus.free_list_out[i] = TW'($urandom_range(32, 63));
            bus.cdb_valid[i]  = 1'($urandom_range(0, 1));
            bus.cdb_tag[i]    = TW'($urandom_range(0, 2) != 0 ? m_tag[$urandom_range(0, 31)]
                                                              : $urandom_range(0, 63));
        end
        bus.free_num = ($clog2(NW) + 1)'($urandom_range(0, NW));
        if ($urandom_range(0, 19) == 0) begin
            bus.squash = 1'b1;
            for (int r = 0; r < 32; r++) bus.arch_map[r] = TW'($urandom_range(0, 63));
        end
        reset = ($urandom_range(0, 99) == 0);
        issue();
        reset = 1'b0;
    endtask

    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            mon_e = exp_q.pop_front();
            check("accept_num", int'(bus.accept_num), mon_e.acc);
            check("dispatch_num", int'(bus.dispatch_num), mon_e.dsp);
            for (int i = 0; i < NW; i++) begin
                if (i < mon_e.acc) begin
                    check($sformatf("rename_T[%0d]", i), int'(bus.rename_T[i]), mon_e.t[i]);
                    if (mon_e.t[i] != 0 || bus.dest_valid[i])
                        if (bus.dest_valid[i] && bus.dest_areg[i] != 0)
                            check($sformatf("rename_Told[%0d]", i), int'(bus.rename_Told[i]), mon_e.told[i]);
                    check($sformatf("src1_tag[%0d]", i), int'(bus.src1_tag[i]), mon_e.s1[i]);
                    check($sformatf("src1_rdy[%0d]", i), int'(bus.src1_rdy[i]), mon_e.r1[i]);
                    check($sformatf("src2_tag[%0d]", i), int'(bus.src2_tag[i]), mon_e.s2[i]);
                    check($sformatf("src2_rdy[%0d]", i), int'(bus.src2_rdy[i]), mon_e.r2[i]);
                end
            end
        end
    end

    initial begin
        n_checks = 0;
        n_fail = 0;
        reset = 1'b1;
        idle();
        @(posedge clk);
        #1;
        issue();
        reset = 1'b0;

        idle(); set_slot(0, 0, 0, 5, 0); issue();
        idle(); set_slot(0, 1, 1, 0, 0); set_slot(1, 2, 1, 0, 0); set_slot(2, 3, 1, 0, 0);
        set_free(40, 41, 42, 3); issue();
        idle(); set_slot(0, 0, 0, 1, 2); issue();
        idle(); set_slot(0, 4, 1, 0, 0); set_slot(1, 4, 1, 0, 0); set_slot(2, 0, 0, 4, 3);
        set_free(50, 51, 52, 2); issue();
        idle(); set_slot(0, 8, 1, 0, 0); set_slot(1, 9, 1, 0, 0); set_slot(2, 10, 1, 0, 0);
        set_free(33, 34, 35, 1); issue();
        idle(); set_slot(0, 11, 1, 0, 0); set_slot(1, 12, 0, 4, 0); set_free(0, 0, 0, 0); issue();
        idle(); set_slot(0, 7, 1, 0, 0); set_free(60, 0, 0, 1); issue();
        idle(); set_slot(0, 0, 0, 7, 7); bus.cdb_valid[0] = 1'b1; bus.cdb_tag[0] = TW'(60); issue();
        idle(); set_slot(0, 0, 0, 7, 0); issue();
        idle(); set_slot(0, 1, 1, 0, 0); set_free(45, 0, 0, 1); bus.squash = 1'b1; issue();
        idle(); set_slot(0, 0, 0, 1, 4); issue();

        for (int n = 0; n < 600; n++) random_cycle();
        idle();

        for (int w = 0; w < 10 && exp_q.size() > 0; w++) @(negedge clk);
        #1;
        if (exp_q.size() > 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/rename_map_table.md
# rename_map_table

Register-rename map table for the N-way superscalar dispatch stage; the consumer end of the free-list allocation interface. Each cycle it takes up to N_WAY in-order instructions, consumes physical tags offered by the free list, returns the count actually taken on `dispatch_num`, and emits renamed destination (T), previous mapping (Told) and source tags with ready bits. It tracks per-architectural-register mappings with ready bits set by CDB broadcasts and restores from the architectural map on squash.

## Interface
- `N_WAY`, 3, dispatch/CDB width (global macro)
- `CDB_BITS`, 6, physical tag width (global macro)
- ARCH_REGS, 32, architectural registers; areg width 5
- clock  in  1  system clock, all state on posedge
- reset  in  1  synchronous, active-high
- inst_valid  in  N_WAY  per-slot instruction valid, contiguous from slot 0
- dest_valid  in  N_WAY  slot writes a destination register
- dest_areg, src1_areg, src2_areg  in  N_WAY x 5  architectural indices
- free_list_out  in  N_WAY x CDB_BITS  free tags; entry k valid for k < free_num
- free_num  in  clog2(N_WAY)+1  number of valid free tags
- cdb_valid  in  N_WAY;  cdb_tag  in  N_WAY x CDB_BITS  completion broadcasts
- squash  in  1  mispredict recovery
- arch_map  in  32 x CDB_BITS  retirement map, sampled on squash
- accept_num  out  clog2(N_WAY)+1  instructions accepted this cycle
- dispatch_num  out  clog2(N_WAY)+1  free tags consumed (to free list)
- rename_T, rename_Told  out  N_WAY x CDB_BITS
- src1_tag, src2_tag  out  N_WAY x CDB_BITS;  src1_rdy, src2_rdy  out  N_WAY

## Operation
- State: per areg a tag (CDB_BITS) and a ready bit.
- Effective dest: dest_valid[i] && dest_areg[i] != 0. x0 never renamed; x0 source yields tag 0, ready 1.
- Acceptance: accept_num = largest k with inst_valid[0..k-1] all set and effective dests among slots 0..k-1 ≤ free_num. dispatch_num = effective dests among accepted slots.
- Allocation: j-th effective dest among accepted slots (j from 0) gets rename_T = free_list_out[j]; non-dest slots output rename_T = 0.
- Told: latest earlier accepted slot in the group writing the same areg supplies its T; otherwise current map tag.
- Sources: latest earlier accepted slot writing the same areg supplies tag with rdy 0; otherwise map tag and stored ready bit.
- Update: accepted effective dests write tag and clear ready; for duplicate areg in a group, highest slot wins.
- CDB: for each valid cdb_tag, any areg whose stored tag matches sets ready, unless that areg is overwritten by dispatch in the same cycle (dispatch wins).
- Squash: map loads arch_map, all ready = 1; overrides dispatch and CDB that cycle. accept_num = dispatch_num = 0 while squash = 1.
- Outputs for slots ≥ accept_num are don't-care; consumers gate with accept_num.

## Timing
- Rename outputs combinational from current state and inputs (0-cycle latency); map updates at next posedge.
- Reset: map[i] = tag i, ready = 1 for all i; accept_num = dispatch_num = 0 while reset = 1; other outputs reflect reset map.
- Reset or squash mid-group discards the whole group; nothing partially committed.
- free_num = 0: only leading non-dest instructions accepted.
- Same-edge CDB and squash: squash only.

## Configuration
- MAP_CDB_BYPASS_EN defined: a source whose map-derived tag matches any valid cdb_tag in the same cycle reports rdy = 1. Intra-group sources are never bypassed.
- Undefined: source rdy comes only from the stored ready bit; a CDB hit is visible the cycle after broadcast.

## Test plan
- Reset, then slot0 src1 = x5, no dest -> src1_tag = 5, src1_rdy = 1, accept_num = 1, dispatch_num = 0.
- 3 valid, dests x1,x2,x3, free_list_out = {40,41,42}, free_num = 3 -> T = 40,41,42; Told = 1,2,3; dispatch_num = 3; next cycle x1 src tag = 40, rdy 0.
- Dests x4,x4; slot2 src1 = x4; free {50,51,52}, free_num = 2 -> Told = 4,50; slot2 src1_tag = 51, rdy 0; map[x4] = 51; accept_num = 3, dispatch_num = 2.
- free_num = 1, three dest-writing slots -> accept_num = 1, dispatch_num = 1.
- map[x7] = 60 pending; cdb_tag 60 valid; same cycle src = x7 -> rdy 1 with MAP_CDB_BYPASS_EN, 0 without; following cycle rdy 1 both.
- Squash with arch_map = identity plus dispatch of x1 -> accept_num = 0, map[x1] = 1, ready = 1 next cycle.
